// File: rtl/char_rom_arbiter.sv
// Two-requester arbiter in front of a shared character ROM with a fixed read latency.
// A tag pipeline routes each ROM result back to the requester that issued the read.
module char_rom_arbiter #(
  parameter int ROM_LAT    = 1,
  parameter int FIXED_PRIO = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0,
  input  logic       req1,
  input  logic [7:0] xy0,
  input  logic [7:0] xy1,
  output logic       ack0,
  output logic       ack1,
  output logic [7:0] rom_xy,
  input  logic [6:0] rom_code,
  output logic       rsp0_valid,
  output logic       rsp1_valid,
  output logic [6:0] rsp_code,
  output logic       busy
);

  logic             grant0;
  logic             grant1;
  logic             accept;
  logic             last_grant;
  logic [7:0]       xy_q;
  logic [6:0]       code_q;
  logic [ROM_LAT:0] vld_p;
  logic [ROM_LAT:0] id_p;

  // last_grant holds the id granted most recently; requester 0 wins a tie when it was 1.
  function automatic logic pick0(input logic r0, input logic r1, input logic lg);
    if (!r0)
      return 1'b0;
    if (!r1)
      return 1'b1;
    return (FIXED_PRIO != 0) || lg;
  endfunction

  always_comb begin
    grant0 = !rst && pick0(req0, req1, last_grant);
    grant1 = !rst && req1 && !grant0;
    accept = grant0 || grant1;
  end

  assign ack0   = grant0;
  assign ack1   = grant1;
  assign rom_xy = rst ? 8'h00 : (accept ? (grant1 ? xy1 : xy0) : xy_q);

  // Accept stage: arbitration state, held address and tag valids
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= 1'b1;
      xy_q       <= 8'h00;
      vld_p      <= '0;
    end else begin
      if (accept) begin
        last_grant <= grant1;
        xy_q       <= rom_xy;
      end
      vld_p <= {vld_p[ROM_LAT-1:0], accept};
    end
  end

  // Tag ids only matter where the matching valid bit is set
  always_ff @(posedge clk) begin
    id_p <= {id_p[ROM_LAT-1:0], grant1};
  end

  // Response stage: capture ROM data in the cycle it is valid for the oldest tag
  always_ff @(posedge clk) begin
    if (rst)
      code_q <= 7'h00;
    else if (vld_p[ROM_LAT-1])
      code_q <= rom_code;
  end

  assign rsp0_valid = !rst && vld_p[ROM_LAT] && !id_p[ROM_LAT];
  assign rsp1_valid = !rst && vld_p[ROM_LAT] &&  id_p[ROM_LAT];
  assign rsp_code   = rst ? 7'h00 : code_q;
  assign busy       = !rst && ((|vld_p) || accept);

endmodule

// File: tb/tb_char_rom_arbiter.sv
// Bench for char_rom_arbiter: three instances (round-robin lat 1, fixed priority lat 1,
// round-robin lat 3) share stimulus; a per-instance model schedules expected responses.
module tb_char_rom_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req0 = 1'b0;
  logic       req1 = 1'b0;
  logic [7:0] xy0 = 8'h00;
  logic [7:0] xy1 = 8'h00;

  logic       ack0_w     [3];
  logic       ack1_w     [3];
  logic [7:0] rom_xy_w   [3];
  logic [6:0] rom_code_w [3];
  logic       rsp0_w     [3];
  logic       rsp1_w     [3];
  logic [6:0] rsp_code_w [3];
  logic       busy_w     [3];

  logic [7:0] d1 [3];
  logic [7:0] d2 [3];
  logic [7:0] d3 [3];

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  bit         sv    [3][8];
  bit         sid   [3][8];
  logic [6:0] scode [3][8];
  int         pend  [3];
  logic       lg    [3];
  logic [6:0] lastc [3];
  logic [7:0] lastxy[3];

  always #5 clk = ~clk;

  char_rom_arbiter #(.ROM_LAT(1), .FIXED_PRIO(0)) u_rr1 (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1), .xy0(xy0), .xy1(xy1),
    .ack0(ack0_w[0]), .ack1(ack1_w[0]), .rom_xy(rom_xy_w[0]), .rom_code(rom_code_w[0]),
    .rsp0_valid(rsp0_w[0]), .rsp1_valid(rsp1_w[0]), .rsp_code(rsp_code_w[0]), .busy(busy_w[0])
  );

  char_rom_arbiter #(.ROM_LAT(1), .FIXED_PRIO(1)) u_fp1 (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1), .xy0(xy0), .xy1(xy1),
    .ack0(ack0_w[1]), .ack1(ack1_w[1]), .rom_xy(rom_xy_w[1]), .rom_code(rom_code_w[1]),
    .rsp0_valid(rsp0_w[1]), .rsp1_valid(rsp1_w[1]), .rsp_code(rsp_code_w[1]), .busy(busy_w[1])
  );

  char_rom_arbiter #(.ROM_LAT(3), .FIXED_PRIO(0)) u_rr3 (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1), .xy0(xy0), .xy1(xy1),
    .ack0(ack0_w[2]), .ack1(ack1_w[2]), .rom_xy(rom_xy_w[2]), .rom_code(rom_code_w[2]),
    .rsp0_valid(rsp0_w[2]), .rsp1_valid(rsp1_w[2]), .rsp_code(rsp_code_w[2]), .busy(busy_w[2])
  );

  function automatic logic [6:0] rom_f(input logic [7:0] a);
    logic [15:0] t;
    t = {8'h00, a} * 16'd37 + 16'd100;
    return t[6:0];
  endfunction

  function automatic int lat_of(input int i);
    return (i == 2) ? 3 : 1;
  endfunction

  function automatic bit fp_of(input int i);
    return (i == 1);
  endfunction

  // ROM model: data follows the presented address after each instance's latency
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      d1[i] <= rom_xy_w[i];
      d2[i] <= d1[i];
      d3[i] <= d2[i];
    end
  end

  assign rom_code_w[0] = rom_f(d1[0]);
  assign rom_code_w[1] = rom_f(d1[1]);
  assign rom_code_w[2] = rom_f(d3[2]);

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  task automatic model_step(input int i);
    string t;
    int    s;
    int    d;
    logic  g0;
    logic  g1;
    bit    hit;
    t = $sformatf("u%0d@%0d", i, cyc);
    s = cyc % 8;
    if (rst) begin
      check_val({t, " rst_ack0"}, 32'(ack0_w[i]), 0);
      check_val({t, " rst_ack1"}, 32'(ack1_w[i]), 0);
      check_val({t, " rst_rsp0"}, 32'(rsp0_w[i]), 0);
      check_val({t, " rst_rsp1"}, 32'(rsp1_w[i]), 0);
      check_val({t, " rst_busy"}, 32'(busy_w[i]), 0);
      check_val({t, " rst_rom_xy"}, 32'(rom_xy_w[i]), 0);
      check_val({t, " rst_code"}, 32'(rsp_code_w[i]), 0);
      for (int k = 0; k < 8; k++) sv[i][k] = 1'b0;
      pend[i]   = 0;
      lg[i]     = 1'b1;
      lastc[i]  = 7'h00;
      lastxy[i] = 8'h00;
    end else begin
      hit = sv[i][s];
      check_val({t, " rsp0"}, 32'(rsp0_w[i]), 32'(hit && !sid[i][s]));
      check_val({t, " rsp1"}, 32'(rsp1_w[i]), 32'(hit && sid[i][s]));
      if (hit) begin
        lastc[i]  = scode[i][s];
        sv[i][s]  = 1'b0;
        pend[i]--;
      end
      check_val({t, " rsp_code"}, 32'(rsp_code_w[i]), 32'(lastc[i]));
      g0 = req0 && (!req1 || fp_of(i) || lg[i]);
      g1 = req1 && !g0;
      check_val({t, " ack0"}, 32'(ack0_w[i]), 32'(g0));
      check_val({t, " ack1"}, 32'(ack1_w[i]), 32'(g1));
      check_val({t, " busy"}, 32'(busy_w[i]), 32'(g0 || g1 || hit || pend[i] > 0));
      if (g0 || g1) begin
        lastxy[i]    = g1 ? xy1 : xy0;
        lg[i]        = g1;
        d            = (cyc + lat_of(i) + 1) % 8;
        sv[i][d]     = 1'b1;
        sid[i][d]    = g1;
        scode[i][d]  = rom_f(lastxy[i]);
        pend[i]++;
      end
      check_val({t, " rom_xy"}, 32'(rom_xy_w[i]), 32'(lastxy[i]));
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) model_step(i);
      cyc++;
    end
  end

  task automatic drive(input logic r, input logic q0, input logic q1,
                       input logic [7:0] a0, input logic [7:0] a1);
    @(posedge clk);
    #1;
    rst  = r;
    req0 = q0;
    req1 = q1;
    xy0  = a0;
    xy1  = a1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
  endtask

  initial begin
    drive(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    drive(1'b1, 1'b1, 1'b1, 8'h33, 8'h44);
    // single request at address 0
    drive(1'b0, 1'b1, 1'b0, 8'h00, 8'h00);
    idle(5);
    // sustained contention
    for (int k = 0; k < 6; k++)
      drive(1'b0, 1'b1, 1'b1, 8'h11 + 8'(k), 8'hA0 + 8'(k));
    idle(6);
    // reset lands while a read is in flight
    drive(1'b0, 1'b0, 1'b1, 8'h00, 8'hF0);
    drive(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    drive(1'b0, 1'b1, 1'b0, 8'h5A, 8'h00);
    idle(6);
    // back-to-back stream from requester 1
    for (int k = 0; k < 16; k++)
      drive(1'b0, 1'b0, 1'b1, 8'h00, 8'(k));
    idle(8);
    for (int k = 0; k < 300; k++)
      drive(($urandom_range(0, 49) == 0), 1'($urandom), 1'($urandom),
            8'($urandom), 8'($urandom));
    idle(8);
    @(negedge clk);
    #1;
    for (int i = 0; i < 3; i++)
      check_val($sformatf("u%0d drain_pending", i), 32'(pend[i]), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
